// File: rtl/traffic_light_monitor.sv
// -----------------------------------------------------------------------------
// traffic_light_monitor
//
// Safety monitor placed between a fixed-time four-way light controller and the
// lamp drivers. Each cycle it checks the controller's four light vectors for
// legal encoding, mutual exclusion, legal colour transitions, green/yellow
// dwell times and the N->S->E->W rotation. Fault-free traffic is forwarded to
// the lamp drivers with one cycle of latency. The first violation latches a
// sticky fault (cause and direction) and forces all lamps to flashing red
// until clr_fault or rst_a.
//
// Ports:
//   clk         system clock, rising edge
//   rst_a       synchronous active-high reset
//   n/s/e/w_lights  controller light vectors (GREEN 001, YELLOW 010, RED 100)
//   clr_fault   synchronous fault clear pulse
//   n/s/e/w_out lamp driver outputs (registered)
//   fault       sticky fault flag
//   fault_code  first fault cause (1 enc, 2 conflict, 3 transition,
//               4 green dwell, 5 yellow dwell, 6 order)
//   fault_dir   direction of first fault (N=0, S=1, E=2, W=3)
// -----------------------------------------------------------------------------
module traffic_light_monitor #(
    parameter int GREEN_CYC  = 8,
    parameter int YELLOW_CYC = 4,
    parameter int FLASH_HALF = 4
) (
    input  logic       clk,
    input  logic       rst_a,
    input  logic [2:0] n_lights,
    input  logic [2:0] s_lights,
    input  logic [2:0] e_lights,
    input  logic [2:0] w_lights,
    input  logic       clr_fault,
    output logic [2:0] n_out,
    output logic [2:0] s_out,
    output logic [2:0] e_out,
    output logic [2:0] w_out,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic [1:0] fault_dir
);

    localparam logic [2:0] GREEN  = 3'b001;
    localparam logic [2:0] YELLOW = 3'b010;
    localparam logic [2:0] RED    = 3'b100;
    localparam logic [2:0] DARK   = 3'b000;

    localparam int CNT_MAX = ((GREEN_CYC > YELLOW_CYC) ? GREEN_CYC : YELLOW_CYC) + 1;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int FW      = $clog2(FLASH_HALF + 1);

    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_SAT  = CW'(CNT_MAX);
    localparam logic [CW-1:0] CNT_GRN  = CW'(GREEN_CYC);
    localparam logic [CW-1:0] CNT_YEL  = CW'(YELLOW_CYC);
    localparam logic [FW-1:0] FL_ONE   = FW'(1);
    localparam logic [FW-1:0] FL_HALF  = FW'(FLASH_HALF);

    function automatic logic legal_enc(input logic [2:0] v);
        return (v == GREEN) || (v == YELLOW) || (v == RED);
    endfunction

    function automatic logic legal_step(input logic [2:0] prv, input logic [2:0] cur);
        logic ok;
        if (prv == cur) begin
            ok = 1'b1;
        end else begin
            case ({prv, cur})
                {RED, GREEN}, {GREEN, YELLOW}, {YELLOW, RED}: ok = 1'b1;
                default:                                      ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

    function automatic logic [1:0] lowest_idx(input logic [3:0] v);
        logic [1:0] idx;
        if (v[0])      idx = 2'd0;
        else if (v[1]) idx = 2'd1;
        else if (v[2]) idx = 2'd2;
        else           idx = 2'd3;
        return idx;
    endfunction

    logic [3:0][2:0]    lights_s;
    logic [3:0][2:0]    prev_q, prev_d, out_q, out_d;
    logic [3:0][CW-1:0] cnt_q, cnt_d;
    logic [3:0]         run_valid_q, run_valid_d;
    logic               last_green_valid_q, last_green_valid_d;
    logic [1:0]         last_green_q, last_green_d;
    logic               fault_q, fault_d;
    logic [2:0]         fault_code_q, fault_code_d;
    logic [1:0]         fault_dir_q, fault_dir_d;
    logic               flash_on_q, flash_on_d;
    logic [FW-1:0]      flash_cnt_q, flash_cnt_d;

    logic [3:0] enc_bad_s, trans_bad_s, gdw_bad_s, ydw_bad_s, ord_bad_s;
    logic [3:0] nonred_s, r2g_s, g2y_s;
    logic       conflict_s, det_s;
    logic [2:0] det_code_s;
    logic [1:0] det_dir_s;

    assign lights_s[0] = n_lights;
    assign lights_s[1] = s_lights;
    assign lights_s[2] = e_lights;
    assign lights_s[3] = w_lights;

    // Per-direction rule checks plus dwell/run/rotation tracking state.
    always_comb begin
        prev_d             = lights_s;
        cnt_d              = cnt_q;
        run_valid_d        = run_valid_q;
        last_green_valid_d = last_green_valid_q;
        last_green_d       = last_green_q;
        enc_bad_s          = 4'b0000;
        trans_bad_s        = 4'b0000;
        gdw_bad_s          = 4'b0000;
        ydw_bad_s          = 4'b0000;
        ord_bad_s          = 4'b0000;
        nonred_s           = 4'b0000;
        r2g_s              = 4'b0000;
        g2y_s              = 4'b0000;
        for (int d = 0; d < 4; d++) begin
            nonred_s[d]    = (lights_s[d] != RED);
            enc_bad_s[d]   = !legal_enc(lights_s[d]);
            // Transition legality only makes sense between two legal colours.
            trans_bad_s[d] = legal_enc(lights_s[d]) && legal_enc(prev_q[d]) &&
                             !legal_step(prev_q[d], lights_s[d]);
            r2g_s[d]       = (prev_q[d] == RED)   && (lights_s[d] == GREEN);
            g2y_s[d]       = (prev_q[d] == GREEN) && (lights_s[d] == YELLOW);
            // cnt_q holds how many samples the previous colour has lasted.
            gdw_bad_s[d]   = run_valid_q[d] &&
                             ((g2y_s[d] && (cnt_q[d] != CNT_GRN)) ||
                              ((prev_q[d] == GREEN) && (lights_s[d] == GREEN) &&
                               (cnt_q[d] == CNT_GRN)));
            ydw_bad_s[d]   = run_valid_q[d] &&
                             (((prev_q[d] == YELLOW) && (lights_s[d] == RED) &&
                               (cnt_q[d] != CNT_YEL)) ||
                              ((prev_q[d] == YELLOW) && (lights_s[d] == YELLOW) &&
                               (cnt_q[d] == CNT_YEL)));
            ord_bad_s[d]   = r2g_s[d] && last_green_valid_q &&
                             (2'(d) != (last_green_q + 2'd1));
            if (lights_s[d] != prev_q[d]) begin
                cnt_d[d] = CNT_ONE;
            end else if (cnt_q[d] == CNT_SAT) begin
                cnt_d[d] = cnt_q[d];
            end else begin
                cnt_d[d] = cnt_q[d] + CNT_ONE;
            end
            run_valid_d[d] = run_valid_q[d] | r2g_s[d] | g2y_s[d];
        end
        // Walk downwards so the lowest-indexed new green becomes the reference.
        for (int d = 3; d >= 0; d--) begin
            if (r2g_s[d]) begin
                last_green_d       = 2'(d);
                last_green_valid_d = 1'b1;
            end else begin
                last_green_d       = last_green_d;
            end
        end
    end

    assign conflict_s = (nonred_s & (nonred_s - 4'd1)) != 4'b0000;

    // Pick the lowest fault code present and its lowest offending direction.
    always_comb begin
        det_s      = 1'b1;
        det_code_s = 3'd0;
        det_dir_s  = 2'd0;
        if (|enc_bad_s) begin
            det_code_s = 3'd1;
            det_dir_s  = lowest_idx(enc_bad_s);
        end else if (conflict_s) begin
            det_code_s = 3'd2;
            det_dir_s  = lowest_idx(nonred_s);
        end else if (|trans_bad_s) begin
            det_code_s = 3'd3;
            det_dir_s  = lowest_idx(trans_bad_s);
        end else if (|gdw_bad_s) begin
            det_code_s = 3'd4;
            det_dir_s  = lowest_idx(gdw_bad_s);
        end else if (|ydw_bad_s) begin
            det_code_s = 3'd5;
            det_dir_s  = lowest_idx(ydw_bad_s);
        end else if (|ord_bad_s) begin
            det_code_s = 3'd6;
            det_dir_s  = lowest_idx(ord_bad_s);
        end else begin
            det_s      = 1'b0;
        end
    end

    // Fault latch, fail-safe flashing and lamp output selection.
    always_comb begin
        fault_d      = fault_q;
        fault_code_d = fault_code_q;
        fault_dir_d  = fault_dir_q;
        flash_on_d   = flash_on_q;
        flash_cnt_d  = flash_cnt_q;
        out_d        = lights_s;
        if (clr_fault) begin
            // Clear wins over anything detected on the same sample.
            fault_d      = 1'b0;
            fault_code_d = 3'd0;
            fault_dir_d  = 2'd0;
            flash_on_d   = 1'b1;
            flash_cnt_d  = FL_ONE;
            out_d        = lights_s;
        end else if (fault_q) begin
            if (flash_cnt_q == FL_HALF) begin
                flash_on_d  = ~flash_on_q;
                flash_cnt_d = FL_ONE;
            end else begin
                flash_cnt_d = flash_cnt_q + FL_ONE;
            end
            out_d = flash_on_d ? {4{RED}} : {4{DARK}};
        end else if (det_s) begin
            // The latch edge is the first cycle of the red half-period.
            fault_d      = 1'b1;
            fault_code_d = det_code_s;
            fault_dir_d  = det_dir_s;
            flash_on_d   = 1'b1;
            flash_cnt_d  = FL_ONE;
            out_d        = {4{RED}};
        end else begin
            out_d        = lights_s;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst_a) begin
            prev_q             <= {4{RED}};
            cnt_q              <= {4{CNT_ZERO}};
            run_valid_q        <= 4'b0000;
            last_green_valid_q <= 1'b0;
            last_green_q       <= 2'd0;
            fault_q            <= 1'b0;
            fault_code_q       <= 3'd0;
            fault_dir_q        <= 2'd0;
            flash_on_q         <= 1'b1;
            flash_cnt_q        <= FL_ONE;
            out_q              <= {4{RED}};
        end else begin
            prev_q             <= prev_d;
            cnt_q              <= cnt_d;
            run_valid_q        <= clr_fault ? 4'b0000 : run_valid_d;
            last_green_valid_q <= clr_fault ? 1'b0 : last_green_valid_d;
            last_green_q       <= last_green_d;
            fault_q            <= fault_d;
            fault_code_q       <= fault_code_d;
            fault_dir_q        <= fault_dir_d;
            flash_on_q         <= flash_on_d;
            flash_cnt_q        <= flash_cnt_d;
            out_q              <= out_d;
        end
    end

    assign n_out      = out_q[0];
    assign s_out      = out_q[1];
    assign e_out      = out_q[2];
    assign w_out      = out_q[3];
    assign fault      = fault_q;
    assign fault_code = fault_code_q;
    assign fault_dir  = fault_dir_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// -----------------------------------------------------------------------------
// tb_traffic_light_monitor
//
// Directed bench for traffic_light_monitor: a long legal rotation, then a
// table of {inputs, expected outputs} rows covering each fault cause, the
// flashing pattern, fault clear with an exempt first run, and reset mid-flash.
// -----------------------------------------------------------------------------
module tb_traffic_light_monitor;

    localparam logic [2:0] G = 3'b001;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] D = 3'b000;
    localparam logic [11:0] ALL_R = {R, R, R, R};
    localparam logic [11:0] ALL_D = {D, D, D, D};

    logic       clk = 1'b0;
    logic       rst_a;
    logic [2:0] n_lights, s_lights, e_lights, w_lights;
    logic       clr_fault;
    logic [2:0] n_out, s_out, e_out, w_out;
    logic       fault;
    logic [2:0] fault_code;
    logic [1:0] fault_dir;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [2:0]  n, s, e, w;
        logic        clr;
        logic        rst;
        logic [11:0] exp_out;
        logic        exp_fault;
        logic [2:0]  exp_code;
        logic [1:0]  exp_dir;
    } vec_t;

    vec_t tbl[$];

    traffic_light_monitor #(
        .GREEN_CYC (8),
        .YELLOW_CYC(4),
        .FLASH_HALF(4)
    ) dut (
        .clk       (clk),
        .rst_a     (rst_a),
        .n_lights  (n_lights),
        .s_lights  (s_lights),
        .e_lights  (e_lights),
        .w_lights  (w_lights),
        .clr_fault (clr_fault),
        .n_out     (n_out),
        .s_out     (s_out),
        .e_out     (e_out),
        .w_out     (w_out),
        .fault     (fault),
        .fault_code(fault_code),
        .fault_dir (fault_dir)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [2:0] n, input logic [2:0] s, input logic [2:0] e,
                       input logic [2:0] w, input logic clr, input logic rst,
                       input logic [11:0] eo, input logic ef, input logic [2:0] ec,
                       input logic [1:0] ed);
        vec_t v;
        v.n = n; v.s = s; v.e = e; v.w = w;
        v.clr = clr; v.rst = rst;
        v.exp_out = eo; v.exp_fault = ef; v.exp_code = ec; v.exp_dir = ed;
        tbl.push_back(v);
    endtask

    // Fault-free row: lamps show this row's inputs after the edge.
    task automatic add_pass(input logic [2:0] n, input logic [2:0] s, input logic [2:0] e,
                            input logic [2:0] w, input logic clr);
        add(n, s, e, w, clr, 1'b0, {n, s, e, w}, 1'b0, 3'd0, 2'd0);
    endtask

    task automatic add_rst();
        add(R, R, R, R, 1'b0, 1'b1, ALL_R, 1'b0, 3'd0, 2'd0);
    endtask

    // Flash rows k = first..first+cnt-1 counted from the latch row (k = 0).
    task automatic add_flash(input int cnt, input int first, input logic [2:0] code,
                             input logic [1:0] dir);
        for (int k = first; k < first + cnt; k++) begin
            add(R, R, R, R, 1'b0, 1'b0, (((k / 4) % 2) == 0) ? ALL_R : ALL_D, 1'b1, code, dir);
        end
    endtask

    // Legal fixed-time schedule: 12-cycle slot per direction, 8 green + 4 yellow.
    function automatic logic [2:0] legal_light(input int d, input int t);
        int ph;
        int act;
        int wi;
        ph  = t % 48;
        act = ph / 12;
        wi  = ph % 12;
        if (act != d) return R;
        else if (wi < 8) return G;
        else return Y;
    endfunction

    initial begin
        logic [11:0] drv;

        rst_a = 1'b1; clr_fault = 1'b0;
        n_lights = R; s_lights = R; e_lights = R; w_lights = R;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("reset out", {20'd0, n_out, s_out, e_out, w_out}, {20'd0, ALL_R});
        check("reset flags", {26'd0, fault, fault_code, fault_dir}, 32'd0);

        // Long legal rotation: pass-through with one cycle latency, no fault.
        rst_a = 1'b0;
        for (int t = 0; t < 400; t++) begin
            drv = {legal_light(0, t), legal_light(1, t), legal_light(2, t), legal_light(3, t)};
            {n_lights, s_lights, e_lights, w_lights} = drv;
            @(posedge clk); #1;
            check($sformatf("legal t=%0d", t),
                  {19'd0, fault, n_out, s_out, e_out, w_out}, {19'd0, 1'b0, drv});
        end

        // Short green: 7 greens then yellow -> code 4 dir N, then flash pattern.
        add_rst();
        for (int i = 0; i < 7; i++) add_pass(G, R, R, R, 1'b0);
        add(Y, R, R, R, 1'b0, 1'b0, ALL_R, 1'b1, 3'd4, 2'd0);
        add_flash(11, 1, 3'd4, 2'd0);

        // Conflict on third S green sample with E green -> code 2 dir S.
        add_rst();
        add_pass(R, G, R, R, 1'b0);
        add_pass(R, G, R, R, 1'b0);
        add(R, G, G, R, 1'b0, 1'b0, ALL_R, 1'b1, 3'd2, 2'd1);
        add_flash(2, 1, 3'd2, 2'd1);

        // Illegal encoding on W while N green -> code 1 dir W.
        add_rst();
        for (int i = 0; i < 3; i++) add_pass(G, R, R, R, 1'b0);
        add(G, R, R, 3'b011, 1'b0, 1'b0, ALL_R, 1'b1, 3'd1, 2'd3);
        add_flash(2, 1, 3'd1, 2'd3);

        // Full N cycle then E green (S skipped) -> code 6 dir E.
        add_rst();
        for (int i = 0; i < 8; i++) add_pass(G, R, R, R, 1'b0);
        for (int i = 0; i < 4; i++) add_pass(Y, R, R, R, 1'b0);
        add(R, R, G, R, 1'b0, 1'b0, ALL_R, 1'b1, 3'd6, 2'd2);
        add_flash(1, 1, 3'd6, 2'd2);

        // N green->red together with S = 110: code 1 beats code 3 -> dir S.
        add_rst();
        for (int i = 0; i < 3; i++) add_pass(G, R, R, R, 1'b0);
        add(R, 3'b110, R, R, 1'b0, 1'b0, ALL_R, 1'b1, 3'd1, 2'd1);
        add_flash(5, 1, 3'd1, 2'd1);

        // Clear mid-flash, E already green: its short first run is exempt.
        add_pass(R, R, G, R, 1'b1);
        for (int i = 0; i < 5; i++) add_pass(R, R, G, R, 1'b0);
        for (int i = 0; i < 4; i++) add_pass(R, R, Y, R, 1'b0);
        for (int i = 0; i < 8; i++) add_pass(R, R, R, G, 1'b0);
        for (int i = 0; i < 4; i++) add_pass(R, R, R, Y, 1'b0);
        for (int i = 0; i < 3; i++) add_pass(G, R, R, R, 1'b0);

        // New fault, flash into the dark half, then reset mid-flash.
        add(3'b011, R, R, R, 1'b0, 1'b0, ALL_R, 1'b1, 3'd1, 2'd0);
        add_flash(5, 1, 3'd1, 2'd0);
        add_rst();
        add_pass(G, R, R, R, 1'b0);

        for (int i = 0; i < tbl.size(); i++) begin
            n_lights  = tbl[i].n;
            s_lights  = tbl[i].s;
            e_lights  = tbl[i].e;
            w_lights  = tbl[i].w;
            clr_fault = tbl[i].clr;
            rst_a     = tbl[i].rst;
            @(posedge clk); #1;
            check($sformatf("row%0d out", i),
                  {20'd0, n_out, s_out, e_out, w_out}, {20'd0, tbl[i].exp_out});
            check($sformatf("row%0d flags", i),
                  {26'd0, fault, fault_code, fault_dir},
                  {26'd0, tbl[i].exp_fault, tbl[i].exp_code, tbl[i].exp_dir});
        end

        clr_fault = 1'b0;
        rst_a     = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
